// File: rtl/product_accumulator.sv
// product_accumulator: sums NUM_TERMS unsigned products into an ACC_W-bit result; define ACC_SATURATE_EN to clamp instead of wrap.
// Latency: acc_valid rises the cycle after the final product is accepted; prod_ready returns the cycle after the result handshake.
// Backpressure: prod_ready is low while a result is held; the held result is released only by acc_valid & acc_ready.
module product_accumulator #(
    parameter int PROD_W    = 8,
    parameter int ACC_W     = 12,
    parameter int NUM_TERMS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] product,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [3:0]        term_cnt,
    output logic              overflow
);
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [3:0]       LAST_TERM = 4'(NUM_TERMS - 1);
    localparam logic [3:0]       ALL_TERMS = 4'(NUM_TERMS);
    localparam logic [ACC_W-1:0] ACC_MAX   = '1;

    state_t           state_q;
    state_t           state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] acc_out_d;
    logic [3:0]       cnt_d;
    logic             ovf_d;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] add_res;
    logic             accept;

    assign prod_ready = (state_q == ACCUM);
    assign acc_valid  = (state_q == HOLD);
    assign accept     = prod_valid & prod_ready;

    // One spare bit catches the carry out of the accumulator.
    assign sum = {1'b0, acc_q} + (ACC_W+1)'(product);

`ifdef ACC_SATURATE_EN
    assign add_res = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
`else
    assign add_res = sum[ACC_W-1:0];
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        acc_out_d = acc_out;
        cnt_d     = term_cnt;
        ovf_d     = overflow;
        if (clear) begin
            // acc_out keeps its stale value; acc_valid is already gated by the state.
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_d = add_res;
                        ovf_d = overflow | sum[ACC_W];
                        if (term_cnt == LAST_TERM) begin
                            acc_out_d = add_res;
                            cnt_d     = ALL_TERMS;
                            state_d   = HOLD;
                        end else begin
                            cnt_d = term_cnt + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (acc_ready) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            acc_out  <= '0;
            term_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            acc_out  <= acc_out_d;
            term_cnt <= cnt_d;
            overflow <= ovf_d;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default build, a 9-bit accumulator and a single-term variant.
module tb_product_accumulator;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       prod_valid;
    logic       acc_ready;
    logic [7:0] product;

    always #5 clk = ~clk;

    logic        a_prdy, a_vld, a_ovf;
    logic [11:0] a_out;
    logic [3:0]  a_cnt;
    logic        b_prdy, b_vld, b_ovf;
    logic [8:0]  b_out;
    logic [3:0]  b_cnt;
    logic        c_prdy, c_vld, c_ovf;
    logic [11:0] c_out;
    logic [3:0]  c_cnt;

    product_accumulator u_dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid), .prod_ready(a_prdy),
        .product(product), .acc_valid(a_vld), .acc_ready(acc_ready), .acc_out(a_out),
        .term_cnt(a_cnt), .overflow(a_ovf));

    product_accumulator #(.ACC_W(9)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid), .prod_ready(b_prdy),
        .product(product), .acc_valid(b_vld), .acc_ready(acc_ready), .acc_out(b_out),
        .term_cnt(b_cnt), .overflow(b_ovf));

    product_accumulator #(.NUM_TERMS(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid), .prod_ready(c_prdy),
        .product(product), .acc_valid(c_vld), .acc_ready(acc_ready), .acc_out(c_out),
        .term_cnt(c_cnt), .overflow(c_ovf));

    typedef struct {
        logic [11:0] val;
        logic        ovf;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    exp_t mon_e;
    int   sel = 0;
    int   errors = 0;
    int   checks = 0;

`ifdef ACC_SATURATE_EN
    localparam logic [11:0] OVF_EXP = 12'h1FF;
`else
    localparam logic [11:0] OVF_EXP = 12'h184;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n      = 1'b0;
        clear      = 1'b0;
        prod_valid = 1'b0;
        acc_ready  = 1'b0;
        product    = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Scoreboard: pops one expected result per acc_valid & acc_ready handshake of the selected DUT.
    always @(negedge clk) begin
        if (rst_n && acc_ready) begin
            if (sel == 0 && a_vld) begin
                chk("a_result_expected", 32'(q_a.size() != 0), 1);
                if (q_a.size() != 0) begin
                    mon_e = q_a.pop_front();
                    chk("a_acc_out", 32'(a_out), 32'(mon_e.val));
                    chk("a_overflow", 32'(a_ovf), 32'(mon_e.ovf));
                end
            end
            if (sel == 1 && b_vld) begin
                chk("b_result_expected", 32'(q_b.size() != 0), 1);
                if (q_b.size() != 0) begin
                    mon_e = q_b.pop_front();
                    chk("b_acc_out", 32'(b_out), 32'(mon_e.val));
                    chk("b_overflow", 32'(b_ovf), 32'(mon_e.ovf));
                end
            end
            if (sel == 2 && c_vld) begin
                chk("c_result_expected", 32'(q_c.size() != 0), 1);
                if (q_c.size() != 0) begin
                    mon_e = q_c.pop_front();
                    chk("c_acc_out", 32'(c_out), 32'(mon_e.val));
                    chk("c_overflow", 32'(c_ovf), 32'(mon_e.ovf));
                end
            end
        end
    end

    logic [7:0] basic_p [4];
    logic [7:0] post_p [4];

    initial begin
        basic_p = '{8'h62, 8'h14, 8'h05, 8'h23};
        post_p  = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Reset state
        rst_n = 1'b0; clear = 1'b0; prod_valid = 1'b0; acc_ready = 1'b0; product = 8'h00;
        #3;
        chk("rst_acc_valid", 32'(a_vld), 0);
        chk("rst_term_cnt", 32'(a_cnt), 0);
        chk("rst_acc_out", 32'(a_out), 0);
        chk("rst_overflow", 32'(a_ovf), 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_prod_ready", 32'(a_prdy), 1);

        // Basic 4-term sum
        sel = 0;
        prod_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            product = basic_p[i];
            if (i == 3) q_a.push_back('{12'h09E, 1'b0});
            tick();
            if (i == 2) begin
                chk("basic_cnt3", 32'(a_cnt), 3);
                chk("basic_not_valid_yet", 32'(a_vld), 0);
            end
        end
        prod_valid = 1'b0;
        chk("basic_valid_latency", 32'(a_vld), 1);
        chk("basic_sum", 32'(a_out), 32'h09E);
        chk("basic_ovf", 32'(a_ovf), 0);
        chk("basic_cnt4", 32'(a_cnt), 4);

        // Backpressure: result must hold while the sink stalls
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_prod_ready_low", 32'(a_prdy), 0);
            chk("bp_acc_out_stable", 32'(a_out), 32'h09E);
        end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        chk("bp_prod_ready_back", 32'(a_prdy), 1);
        chk("bp_cnt_cleared", 32'(a_cnt), 0);
        chk("bp_valid_dropped", 32'(a_vld), 0);

        // Overflow on a 9-bit accumulator: 4 x 0xE1 = 900
        do_reset();
        sel = 1;
        prod_valid = 1'b1;
        product = 8'hE1;
        q_b.push_back('{OVF_EXP, 1'b1});
        tick();
        tick();
        chk("ovf_not_yet", 32'(b_ovf), 0);
        tick();
        chk("ovf_sticky_set", 32'(b_ovf), 1);
        tick();
        prod_valid = 1'b0;
        chk("ovf_valid", 32'(b_vld), 1);
        chk("ovf_acc_out", 32'(b_out), 32'(OVF_EXP));
        chk("ovf_flag", 32'(b_ovf), 1);
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        chk("ovf_cleared_on_handshake", 32'(b_ovf), 0);

        // Clear mid-sum drops the partial sum and the product presented with it
        do_reset();
        sel = 0;
        prod_valid = 1'b1;
        product = 8'h10;
        tick();
        tick();
        chk("clr_cnt2", 32'(a_cnt), 2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_cnt0", 32'(a_cnt), 0);
        chk("clr_not_valid", 32'(a_vld), 0);
        product = 8'h01;
        q_a.push_back('{12'h004, 1'b0});
        repeat (4) tick();
        prod_valid = 1'b0;
        chk("clr_after_valid", 32'(a_vld), 1);
        chk("clr_after_sum", 32'(a_out), 32'h004);
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;

        // Async reset mid-sum
        prod_valid = 1'b1;
        product = 8'h40;
        repeat (3) tick();
        prod_valid = 1'b0;
        chk("areset_pre_cnt", 32'(a_cnt), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_cnt", 32'(a_cnt), 0);
        chk("areset_acc_out", 32'(a_out), 0);
        chk("areset_valid", 32'(a_vld), 0);
        tick();
        rst_n = 1'b1;
        prod_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            product = post_p[i];
            if (i == 3) q_a.push_back('{12'h0AA, 1'b0});
            tick();
        end
        prod_valid = 1'b0;
        chk("areset_post_sum", 32'(a_out), 32'h0AA);
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;

        // NUM_TERMS=1: each accept is a complete result
        do_reset();
        sel = 2;
        acc_ready = 1'b1;
        prod_valid = 1'b1;
        product = 8'h31;
        q_c.push_back('{12'h031, 1'b0});
        tick();
        prod_valid = 1'b0;
        chk("one_valid1", 32'(c_vld), 1);
        chk("one_ready_low", 32'(c_prdy), 0);
        chk("one_out1", 32'(c_out), 32'h031);
        tick();
        chk("one_ready_back", 32'(c_prdy), 1);
        chk("one_valid_idle", 32'(c_vld), 0);
        prod_valid = 1'b1;
        product = 8'h0A;
        q_c.push_back('{12'h00A, 1'b0});
        tick();
        prod_valid = 1'b0;
        chk("one_valid2", 32'(c_vld), 1);
        chk("one_out2", 32'(c_out), 32'h00A);
        tick();
        acc_ready = 1'b0;
        tick();

        chk("q_a_drained", 32'(q_a.size()), 0);
        chk("q_b_drained", 32'(q_b.size()), 0);
        chk("q_c_drained", 32'(q_c.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 4-bit multiplier's 8-bit product.
- Accepts a stream of products over a valid/ready handshake and sums NUM_TERMS of them into a wider accumulator.
- Presents the finished dot-product-style sum on an output valid/ready handshake.
- Sits between the combinational multiplier (plus its operand sequencing) and any result sink.

Parameters:
- PROD_W, 8, width of incoming product (matches 4x4 multiplier output).
- ACC_W, 12, accumulator/result width; legal range PROD_W..32.
- NUM_TERMS, 4, products summed per result; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous abort: discard partial/held sum
- prod_valid  input  1  product word valid
- prod_ready  output  1  block can accept a product this cycle
- product  input  PROD_W  unsigned product from multiplier
- acc_valid  output  1  result valid
- acc_ready  input  1  sink accepts result
- acc_out  output  ACC_W  accumulated unsigned result
- term_cnt  output  4  products accepted into the current sum
- overflow  output  1  current/held sum exceeded ACC_W range

Behaviour:
- Reset (rst_n low, async): state=ACCUM, acc register=0, acc_out=0, term_cnt=0, acc_valid=0, overflow=0. prod_ready is combinational from state, so it is 1 once rst_n deasserts.
- Two states:
  - ACCUM: prod_ready=1, acc_valid=0.
  - HOLD: prod_ready=0, acc_valid=1.
- Product accept = prod_valid & prod_ready, sampled on the rising edge.
- ACCUM, accept, term_cnt < NUM_TERMS-1:
  - acc <= acc + product (zero-extended).
  - term_cnt <= term_cnt+1.
- ACCUM, accept, term_cnt == NUM_TERMS-1:
  - acc_out <= acc + product.
  - acc_valid <= 1; state <= HOLD.
  - term_cnt <= NUM_TERMS (holds during HOLD).
  - Latency: acc_valid is high the cycle after the final accept.
- ACCUM, no accept: everything holds. prod_valid may toggle freely while prod_ready=1.
- HOLD:
  - acc_out, overflow and term_cnt stay stable until acc_ready=1.
  - On the acc_valid & acc_ready edge: acc<=0, term_cnt<=0, overflow<=0, acc_valid<=0, state<=ACCUM.
  - No product is accepted in the handshake cycle; the next accept is possible one cycle later.
- Arithmetic:
  - Sum is computed at ACC_W+1 bits; bit ACC_W set means overflow.
  - Without the optional feature the stored value wraps modulo 2^ACC_W.
  - overflow is sticky from the first wrapping add until the result handshake or clear.
- NUM_TERMS=1: every accepted product goes straight to HOLD; acc_out = product.
- clear:
  - Priority: below rst_n, above all else.
  - Next edge: state<=ACCUM, acc=0, term_cnt=0, overflow=0, acc_valid=0.
  - Any product presented that cycle is dropped. acc_out retains its last value but is not valid.
- Reset mid-operation: async, immediate return to the reset values above. No partial result is emitted.
- product must be stable while prod_valid=1 and prod_ready=0. This case never occurs in ACCUM.

Optional Feature:
- Macro ACC_SATURATE_EN.
- Defined: any add whose ACC_W+1-bit sum exceeds 2^ACC_W-1 clamps acc (and acc_out on the final term) to 2^ACC_W-1. overflow is still set and sticky, and later adds stay clamped.
- Undefined: modulo-2^ACC_W wrap as described in Behaviour.

Test Plan:
- Basic sum, defaults:
  - Products 0x62, 0x14, 0x05, 0x23 (prod_valid held high) -> acc_valid rises the cycle after the 4th accept.
  - acc_out=0x09E, overflow=0, term_cnt=4.
- Backpressure:
  - Same stream with acc_ready=0 for 5 cycles -> prod_ready=0 and acc_out stable at 0x09E throughout.
  - Single handshake on acc_ready=1, then prod_ready=1 the next cycle with term_cnt=0.
- Overflow, ACC_W=9:
  - Four products of 0xE1 -> without ACC_SATURATE_EN: acc_out=0x184, overflow=1.
  - With ACC_SATURATE_EN: acc_out=0x1FF, overflow=1.
- Clear mid-sum:
  - Accept 0x10, 0x10, pulse clear (with prod_valid=1, product=0x10) -> term_cnt=0.
  - Then four 0x01 -> acc_out=0x004.
- Async reset mid-sum:
  - After 3 accepts, drop rst_n between clock edges -> acc_valid, term_cnt and acc_out go 0 immediately without a clock edge.
  - After release, the next full 4-term sum is correct.
- NUM_TERMS=1:
  - Products 0x31 then 0x0A with acc_ready=1 -> two results 0x031 and 0x00A.
  - Each appears one cycle after its accept, with an idle (prod_ready=0) cycle between accepts.
